logic_seq: RTL and testbench

//  Issue/sequencing stage placed directly upstream of the 16-bit logical unit.
//  - Accepts one request at a time over a valid/ready handshake: opcode, operands, shift count.
//  - Decodes the 4-bit opcode into the ASCII select string the logical unit expects.
//  - Iterates single-bit shift/rotate ops N times by feeding lu_x back into lu_a.
//  - Registers the result with flags and presents it over an output valid/ready handshake.

---
 rtl/logic_seq.sv | 152 +++++++++++++++
 tb/tb_logic_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_seq.sv
// logic_seq: issue/sequencing stage in front of the 16-bit logical unit.
// Takes one request at a time, decodes the opcode into the unit's ASCII
// select string, and repeats single-bit shift/rotate ops by feeding the unit's
// output back into its a operand. The result and its flags are then held until
// the consumer takes them.
// Optional feature: define LOGIC_SEQ_CARRY_EN to add the out_c carry output.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload stable until that edge. in_ready is
// high only in IDLE outside reset. out_valid stays high, with out_x and the
// flags stable, until the edge where out_ready is also high.
module logic_seq #(
    parameter int CNT_W = 4,
    parameter int SEL_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [CNT_W-1:0] in_cnt,
    output logic [15:0]      lu_a,
    output logic [15:0]      lu_b,
    output logic [SEL_W-1:0] lu_sel,
    input  logic [15:0]      lu_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_x,
    output logic             out_z,
    output logic             out_n,
    output logic             out_err,
`ifdef LOGIC_SEQ_CARRY_EN
    output logic             out_c,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [15:0]      acc;
    logic [15:0]      b_r;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] rem;
    logic [23:0]      sel24;
    logic             in_shift;
    logic             op_shift;

    // Opcodes 7..12 are the single-bit shift/rotate family that gets iterated.
    assign in_shift = (in_op >= 4'd7) && (in_op <= 4'd12);
    assign op_shift = (op_r >= 4'd7) && (op_r <= 4'd12);

`ifdef LOGIC_SEQ_CARRY_EN
    logic carry_bit;
    // Left-going ops lose bit 15, right-going ops lose bit 0.
    assign carry_bit = (op_r == 4'd7 || op_r == 4'd9 || op_r == 4'd11) ? acc[15] : acc[0];
`endif

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign lu_a      = acc;
    assign lu_b      = b_r;
    assign dbg_state = state;
    assign lu_sel    = {{(SEL_W-24){1'b0}}, sel24};

    // Opcode to ASCII select string. Illegal opcodes select nothing, so the unit returns 0.
    always_comb begin
        sel24 = 24'd0;
        case (op_r)
            4'd0:    sel24 = {16'd0, "~"};
            4'd1:    sel24 = {16'd0, "|"};
            4'd2:    sel24 = {16'd0, "&"};
            4'd3:    sel24 = {8'd0, "~&"};
            4'd4:    sel24 = {8'd0, "~|"};
            4'd5:    sel24 = {16'd0, "^"};
            4'd6:    sel24 = {8'd0, "~^"};
            4'd7:    sel24 = {8'd0, "<<"};
            4'd8:    sel24 = {8'd0, ">>"};
            4'd9:    sel24 = "asl";
            4'd10:   sel24 = "asr";
            4'd11:   sel24 = "rol";
            4'd12:   sel24 = "ror";
            4'd13:   sel24 = "cmp";
            default: sel24 = 24'd0;
        endcase
    end

    // Sequencer: accept, iterate through the unit, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 16'd0;
            b_r     <= 16'd0;
            op_r    <= 4'd0;
            rem     <= '0;
            out_x   <= 16'd0;
            out_z   <= 1'b0;
            out_n   <= 1'b0;
            out_err <= 1'b0;
`ifdef LOGIC_SEQ_CARRY_EN
            out_c   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= in_a;
                        b_r  <= in_b;
                        op_r <= in_op;
                        rem  <= in_shift ? in_cnt : CNT_W'(1);
`ifdef LOGIC_SEQ_CARRY_EN
                        out_c <= 1'b0;
`endif
                        if (in_shift && (in_cnt == '0)) begin
                            // Zero-count shift: the operand passes through untouched.
                            out_x   <= in_a;
                            out_z   <= (in_a == 16'd0);
                            out_n   <= in_a[15];
                            out_err <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= lu_x;
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        out_x   <= lu_x;
                        out_z   <= (lu_x == 16'd0);
                        out_n   <= lu_x[15];
                        out_err <= (op_r >= 4'd14);
`ifdef LOGIC_SEQ_CARRY_EN
                        out_c   <= op_shift ? carry_bit : 1'b0;
`endif
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_seq.sv
// Directed bench for logic_seq. It includes a behavioural model of the
// logical unit, so lu_x is computed from lu_a, lu_b and lu_sel. The select
// codes are written here as raw ASCII hex.
module tb_logic_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_cnt;
    logic [15:0] lu_a;
    logic [15:0] lu_b;
    logic [24:0] lu_sel;
    logic [15:0] lu_x;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_z;
    logic        out_n;
    logic        out_err;
    logic [1:0]  dbg_state;
`ifdef LOGIC_SEQ_CARRY_EN
    logic        out_c;
`endif

    int total;
    int bad;
    logic [15:0] exp_q[$];

    logic_seq #(.CNT_W(4), .SEL_W(25)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cnt(in_cnt),
        .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_x(lu_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_z(out_z), .out_n(out_n), .out_err(out_err),
`ifdef LOGIC_SEQ_CARRY_EN
        .out_c(out_c),
`endif
        .dbg_state(dbg_state)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logical unit model
    always_comb begin
        lu_x = 16'h0000;
        case (lu_sel)
            25'h00007E: lu_x = ~lu_a;
            25'h00007C: lu_x = lu_a | lu_b;
            25'h000026: lu_x = lu_a & lu_b;
            25'h007E26: lu_x = ~(lu_a & lu_b);
            25'h007E7C: lu_x = ~(lu_a | lu_b);
            25'h00005E: lu_x = lu_a ^ lu_b;
            25'h007E5E: lu_x = ~(lu_a ^ lu_b);
            25'h003C3C: lu_x = {lu_a[14:0], 1'b0};
            25'h003E3E: lu_x = {1'b0, lu_a[15:1]};
            25'h61736C: lu_x = {lu_a[14:0], 1'b0};
            25'h617372: lu_x = {lu_a[15], lu_a[15:1]};
            25'h726F6C: lu_x = {lu_a[14:0], lu_a[15]};
            25'h726F72: lu_x = {lu_a[0], lu_a[15:1]};
            25'h636D70: lu_x = ($signed(lu_a) < $signed(lu_b)) ? 16'hFFFF :
                               (lu_a == lu_b) ? 16'h0000 : 16'h0001;
            default:    lu_x = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: issue one request and check its result, latency and flags.
    // It is entered and left #1 after a rising edge.
    task automatic run_req(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] cnt, input int exp_lat,
                           input logic [15:0] exp_x, input logic exp_z, input logic exp_n,
                           input logic exp_err, input logic exp_c);
        int guard;
        int lat;
        logic [15:0] ex;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_cnt = cnt;
        exp_q.push_back(exp_x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        ex = exp_q.pop_front();
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_x"}, 32'(out_x), 32'(ex));
        check({tag, "_z"}, 32'(out_z), 32'(exp_z));
        check({tag, "_n"}, 32'(out_n), 32'(exp_n));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
`ifdef LOGIC_SEQ_CARRY_EN
        check({tag, "_c"}, 32'(out_c), 32'(exp_c));
`else
        if (exp_c) begin end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int seen;
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 4'd0;
        in_a = 16'd0;
        in_b = 16'd0;
        in_cnt = 4'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_x", 32'(out_x), 32'd0);
        check("rst_flags", {29'd0, out_z, out_n, out_err}, 32'd0);
        check("rst_iready", 32'(in_ready), 32'd0);
        check("rst_sel", 32'(lu_sel), 32'h7E);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("idle_iready", 32'(in_ready), 32'd1);

        // Two-operand and compare ops, plus the illegal opcode
        run_req("and", 4'd2, 16'hF0F0, 16'h3C3C, 4'd0, 2, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
        run_req("not", 4'd0, 16'h00FF, 16'h1234, 4'd9, 2, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_req("cmp", 4'd13, 16'h0003, 16'h0005, 4'd0, 2, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_req("xnor", 4'd6, 16'h1234, 16'h1234, 4'd0, 2, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_req("ill15", 4'd15, 16'hABCD, 16'h1111, 4'd3, 2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Iterated shift/rotate ops, including the zero and maximum counts
        run_req("rol4", 4'd11, 16'h8001, 16'h0000, 4'd4, 5, 16'h0018, 1'b0, 1'b0, 1'b0, 1'b0);
        run_req("asr0", 4'd10, 16'h8000, 16'h0000, 4'd0, 1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_req("asr15", 4'd10, 16'h8000, 16'h0000, 4'd15, 16, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_req("shr2", 4'd8, 16'h0003, 16'h0000, 4'd2, 3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_req("asl1", 4'd9, 16'hC000, 16'h0000, 4'd1, 2, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Output back-pressure with a second request already waiting
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 4'd1;
        in_a = 16'h0F00;
        in_b = 16'h00F0;
        in_cnt = 4'd0;
        @(posedge clk); #1;
        in_op = 4'd5;
        in_a = 16'hFFFF;
        in_b = 16'h0F0F;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check("stall_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_x", 32'(out_x), 32'h0FF0);
            check("stall_iready", 32'(in_ready), 32'd0);
            if (i < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hs_state", 32'(dbg_state), 32'd0);
        check("hs_iready", 32'(in_ready), 32'd1);
        check("hs_ovalid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check("second_lat", 32'(lat), 32'd2);
        check("second_x", 32'(out_x), 32'hF0F0);
        check("second_n", 32'(out_n), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a long shift
        in_valid = 1'b1;
        in_op = 4'd7;
        in_a = 16'h0001;
        in_b = 16'h5555;
        in_cnt = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_state", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", 32'(dbg_state), 32'd0);
        check("abort_ovalid", 32'(out_valid), 32'd0);
        check("abort_x", 32'(out_x), 32'd0);
        check("abort_flags", {29'd0, out_z, out_n, out_err}, 32'd0);
        check("abort_lua", 32'(lu_a), 32'd0);
        check("abort_lub", 32'(lu_b), 32'd0);
        check("abort_sel", 32'(lu_sel), 32'h7E);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_never", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // Normal operation after the abort
        run_req("nor", 4'd4, 16'h0000, 16'h0000, 4'd0, 2, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
